hazard_control_unit: RTL and testbench

Producer end of the operand-forwarding path. Carries destination tags (Rd, RegWrite, MemRead, MemAccess) down the EX, MEM and WB stages and drives the Rd_EX, Rd_MEM, RegWrite_EX and RegWrite_MEM signals used by the forwarding mux control. Detects load-use hazards that forwarding cannot cover and inserts one-cycle bubbles. Freezes the pipeline while data memory is not ready, and squashes IF/ID on a taken branch.

---
 rtl/hazard_pkg.sv | 38 +++
 rtl/hazard_stage_reg.sv | 41 ++++
 rtl/hazard_control_unit.sv | 185 ++++++++++++++++++
 tb/tb_hazard_control_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the hazard/forwarding control slice.
//   stage_tag_t : destination tag carried down EX, MEM and WB
//   BUBBLE_TAG  : tag value of an empty (NOP) stage
//   ZERO_REG    : architectural zero register, never a forwarding source
//   hz_state_t  : control FSM states
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_access;
  } stage_tag_t;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hz_state_t;

  // Builds the empty-stage tag for a given zero register, so a top level that
  // overrides its zero register still gets consistent bubbles.
  function automatic stage_tag_t make_bubble(input logic [4:0] zero_reg);
    stage_tag_t t;
    t.rd         = zero_reg;
    t.reg_write  = 1'b0;
    t.mem_read   = 1'b0;
    t.mem_access = 1'b0;
    return t;
  endfunction

  localparam stage_tag_t BUBBLE_TAG = make_bubble(ZERO_REG);

endpackage

// File: rtl/hazard_stage_reg.sv
// ---------------------------------------------------------------------------
// hazard_stage_reg
// One pipeline tag register with hold (freeze) and bubble (insert NOP)
// controls. Hold wins over bubble; reset always loads the bubble value.
//   clk, reset : clock and synchronous active-high reset
//   hold       : keep the current tag
//   bubble     : load BUBBLE_VAL instead of tag_in
//   tag_in     : tag from the previous stage
//   tag_q      : registered tag
// ---------------------------------------------------------------------------
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter stage_tag_t BUBBLE_VAL = BUBBLE_TAG
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic       bubble,
  input  stage_tag_t tag_in,
  output stage_tag_t tag_q
);

  stage_tag_t tag_d;

  always_comb begin
    tag_d = tag_q;
    if (!hold) begin
      tag_d = bubble ? BUBBLE_VAL : tag_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= BUBBLE_VAL;
    end else begin
      tag_q <= tag_d;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
// Carries destination tags down EX/MEM/WB for the forwarding mux control,
// inserts one bubble per load-use hazard, freezes the pipeline while data
// memory is busy, and squashes IF/ID on a taken branch.
//   Inputs : clk, reset, ID-stage tags (Rd/RegWrite/MemRead/MemAccess),
//            ID source registers and use flags, branch_taken, mem_ready
//   Outputs: registered EX/MEM/WB tags, pc_write, ifid_write, ifid_flush,
//            idex_bubble (all combinational), sticky mem_timeout,
//            saturating stall_count
// ---------------------------------------------------------------------------
module hazard_control_unit #(
  parameter logic [4:0] ZERO_REG = hazard_pkg::ZERO_REG,
  parameter int         TIMEOUT  = 16,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rd_ID,
  input  logic             RegWrite_ID,
  input  logic             MemRead_ID,
  input  logic             MemAccess_ID,
  input  logic [4:0]       AddrA_ID,
  input  logic [4:0]       AddrB_ID,
  input  logic             UsesA_ID,
  input  logic             UsesB_ID,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic [4:0]       Rd_EX,
  output logic [4:0]       Rd_MEM,
  output logic [4:0]       Rd_WB,
  output logic             RegWrite_EX,
  output logic             RegWrite_MEM,
  output logic             RegWrite_WB,
  output logic             MemRead_EX,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  import hazard_pkg::*;

  localparam int         WAIT_W     = $clog2(TIMEOUT + 1);
  localparam stage_tag_t BUBBLE_VAL = make_bubble(ZERO_REG);

  // Stage index 0 = EX, 1 = MEM, 2 = WB.
  stage_tag_t id_tag;
  stage_tag_t stage_in [3];
  stage_tag_t stage_q  [3];

  logic load_use;
  logic mem_wait;
  logic stage_hold;

  hz_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  assign id_tag = '{rd: Rd_ID, reg_write: RegWrite_ID,
                    mem_read: MemRead_ID, mem_access: MemAccess_ID};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stage
      if (gi == 0) begin : g_src_id
        assign stage_in[gi] = id_tag;
      end else begin : g_src_prev
        assign stage_in[gi] = stage_q[gi-1];
      end

      hazard_stage_reg #(
        .BUBBLE_VAL (BUBBLE_VAL)
      ) u_stage (
        .clk    (clk),
        .reset  (reset),
        .hold   (stage_hold),
        .bubble ((gi == 0) ? idex_bubble : 1'b0),
        .tag_in (stage_in[gi]),
        .tag_q  (stage_q[gi])
      );
    end
  endgenerate

  // Hazard detection. A load targeting the zero register never stalls,
  // since nothing real is produced for the consumer to wait on.
  always_comb begin
    load_use = stage_q[0].mem_read & stage_q[0].reg_write &
               (stage_q[0].rd != ZERO_REG) &
               ((UsesA_ID & (AddrA_ID == stage_q[0].rd)) |
                (UsesB_ID & (AddrB_ID == stage_q[0].rd)));
    mem_wait = stage_q[1].mem_access & ~mem_ready;
  end

  // Pipeline control, priority reset > mem_wait > branch > load_use.
  // A branch squashes the load-use consumer, so no stall is needed then.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stage_hold  = 1'b0;
    if (!reset) begin
      if (mem_wait) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        stage_hold = 1'b1;
      end else if (branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  // Memory-wait FSM. The wait counter holds the number of stalled cycles of
  // the current access: the first frozen cycle (still in RUN) counts as one.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_count_d = stall_count_q;

    case (state_q)
      RUN: begin
        wait_cnt_d = '0;
        if (mem_wait) begin
          state_d    = MEMWAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEMWAIT: begin
        if (mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_W'(TIMEOUT)) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    // The FSM keeps waiting after a timeout; the flag only reports it.
    if (wait_cnt_d == WAIT_W'(TIMEOUT)) begin
      mem_timeout_d = 1'b1;
    end

    if (!pc_write && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign Rd_EX        = stage_q[0].rd;
  assign Rd_MEM       = stage_q[1].rd;
  assign Rd_WB        = stage_q[2].rd;
  assign RegWrite_EX  = stage_q[0].reg_write;
  assign RegWrite_MEM = stage_q[1].reg_write;
  assign RegWrite_WB  = stage_q[2].reg_write;
  assign MemRead_EX   = stage_q[0].mem_read;
  assign mem_timeout  = mem_timeout_q;
  assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_control_unit
// Directed stimulus; each cycle the stimulus process pushes hand-computed
// expectations into a scoreboard queue, and a monitor on the falling edge
// pops and compares them against the DUT outputs.
// Expectation kinds: 0 = control {pc_write, ifid_write, ifid_flush,
// idex_bubble}; 1 = tags {Rd_EX, Rd_MEM, Rd_WB, RegWrite_EX/MEM/WB,
// MemRead_EX}; 2 = misc {mem_timeout, stall_count}.
// ---------------------------------------------------------------------------
module tb_hazard_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Rd_ID;
  logic        RegWrite_ID, MemRead_ID, MemAccess_ID;
  logic [4:0]  AddrA_ID, AddrB_ID;
  logic        UsesA_ID, UsesB_ID;
  logic        branch_taken, mem_ready;
  logic [4:0]  Rd_EX, Rd_MEM, Rd_WB;
  logic        RegWrite_EX, RegWrite_MEM, RegWrite_WB, MemRead_EX;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, mem_timeout;
  logic [15:0] stall_count;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] value;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(
    .ZERO_REG (5'd31),
    .TIMEOUT  (16),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Rd_ID        (Rd_ID),
    .RegWrite_ID  (RegWrite_ID),
    .MemRead_ID   (MemRead_ID),
    .MemAccess_ID (MemAccess_ID),
    .AddrA_ID     (AddrA_ID),
    .AddrB_ID     (AddrB_ID),
    .UsesA_ID     (UsesA_ID),
    .UsesB_ID     (UsesB_ID),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .Rd_EX        (Rd_EX),
    .Rd_MEM       (Rd_MEM),
    .Rd_WB        (Rd_WB),
    .RegWrite_EX  (RegWrite_EX),
    .RegWrite_MEM (RegWrite_MEM),
    .RegWrite_WB  (RegWrite_WB),
    .MemRead_EX   (MemRead_EX),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .mem_timeout  (mem_timeout),
    .stall_count  (stall_count)
  );

  function automatic logic [31:0] observe(input int kind);
    logic [31:0] v;
    v = '0;
    case (kind)
      0: v = {28'b0, pc_write, ifid_write, ifid_flush, idex_bubble};
      1: v = {14'b0, Rd_EX, Rd_MEM, Rd_WB, RegWrite_EX, RegWrite_MEM,
              RegWrite_WB, MemRead_EX};
      default: v = {15'b0, mem_timeout, stall_count};
    endcase
    return v;
  endfunction

  // Monitor: compares every expectation queued for the current cycle.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = observe(e.kind);
      n_checks++;
      if (act !== e.value) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.value);
      end else begin
        $display("ok   %s: %h", e.name, act);
      end
    end
  end

  task automatic exp_ctl(input string nm, input logic pc, input logic ifw,
                         input logic fl, input logic bub);
    exp_t e;
    e.name  = nm;
    e.kind  = 0;
    e.value = {28'b0, pc, ifw, fl, bub};
    sb_q.push_back(e);
  endtask

  task automatic exp_tags(input string nm, input logic [4:0] rd_ex,
                          input logic [4:0] rd_mem, input logic [4:0] rd_wb,
                          input logic rw_ex, input logic rw_mem,
                          input logic rw_wb, input logic mr_ex);
    exp_t e;
    e.name  = nm;
    e.kind  = 1;
    e.value = {14'b0, rd_ex, rd_mem, rd_wb, rw_ex, rw_mem, rw_wb, mr_ex};
    sb_q.push_back(e);
  endtask

  task automatic exp_misc(input string nm, input logic tmo,
                          input logic [15:0] sc);
    exp_t e;
    e.name  = nm;
    e.kind  = 2;
    e.value = {15'b0, tmo, sc};
    sb_q.push_back(e);
  endtask

  task automatic nop_in();
    Rd_ID        = 5'd31;
    RegWrite_ID  = 1'b0;
    MemRead_ID   = 1'b0;
    MemAccess_ID = 1'b0;
    AddrA_ID     = 5'd31;
    AddrB_ID     = 5'd31;
    UsesA_ID     = 1'b0;
    UsesB_ID     = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] rd, input logic rw, input logic mr,
                        input logic ma);
    Rd_ID        = rd;
    RegWrite_ID  = rw;
    MemRead_ID   = mr;
    MemAccess_ID = ma;
  endtask

  task automatic set_src(input logic [4:0] a, input logic ua,
                         input logic [4:0] b, input logic ub);
    AddrA_ID = a;
    UsesA_ID = ua;
    AddrB_ID = b;
    UsesB_ID = ub;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset        = 1'b1;
    nop_in();
    branch_taken = 1'b1;
    mem_ready    = 1'b1;
    tick();

    // Reset cycle: a pending branch must not reach the control outputs.
    exp_ctl("rst_ctl", 1, 1, 0, 0);
    exp_tags("rst_tags", 31, 31, 31, 0, 0, 0, 0);
    exp_misc("rst_misc", 0, 16'd0);
    tick();
    reset        = 1'b0;
    branch_taken = 1'b0;
    exp_ctl("idle_ctl", 1, 1, 0, 0);
    exp_tags("idle_tags", 31, 31, 31, 0, 0, 0, 0);
    tick();

    // Load x5, then consumer of x5 on port A: exactly one bubble.
    set_id(5, 1, 1, 1);
    exp_ctl("lu_load_ctl", 1, 1, 0, 0);
    tick();
    set_id(6, 1, 0, 0);
    set_src(5, 1, 31, 0);
    exp_ctl("lu_stall_ctl", 0, 0, 0, 1);
    exp_tags("lu_stall_tags", 5, 31, 31, 1, 0, 0, 1);
    tick();
    exp_ctl("lu_resume_ctl", 1, 1, 0, 0);
    exp_tags("lu_fwd_tags", 31, 5, 31, 0, 1, 0, 0);
    exp_misc("lu_count", 0, 16'd1);
    tick();
    nop_in();
    exp_tags("lu_drain_tags", 6, 31, 5, 1, 0, 1, 0);
    tick();

    // Load into x31 followed by a consumer of x31: no stall.
    set_id(31, 1, 1, 1);
    exp_ctl("zr_load_ctl", 1, 1, 0, 0);
    tick();
    set_id(7, 1, 0, 0);
    set_src(31, 1, 31, 1);
    exp_ctl("zr_nostall_ctl", 1, 1, 0, 0);
    exp_tags("zr_tags", 31, 31, 6, 1, 0, 1, 1);
    tick();
    nop_in();
    exp_tags("zr_adv_tags", 7, 31, 31, 1, 1, 0, 0);
    exp_misc("zr_count", 0, 16'd1);
    tick();

    // Load x8 in EX, consumer on port B, branch taken the same cycle.
    set_id(8, 1, 1, 1);
    tick();
    set_id(9, 1, 0, 0);
    set_src(31, 0, 8, 1);
    branch_taken = 1'b1;
    exp_ctl("br_lu_ctl", 1, 1, 1, 1);
    exp_tags("br_lu_tags", 8, 31, 7, 1, 0, 1, 1);
    tick();
    branch_taken = 1'b0;
    nop_in();
    exp_ctl("br_after_ctl", 1, 1, 0, 0);
    exp_tags("br_bubble_tags", 31, 8, 31, 0, 1, 0, 0);
    exp_misc("br_count", 0, 16'd1);
    tick();

    // Store reaches MEM, memory busy for 3 cycles (branch ignored while frozen).
    set_id(31, 0, 0, 1);
    tick();
    set_id(10, 1, 0, 0);
    tick();
    set_id(11, 1, 0, 0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      branch_taken = (i == 1);
      exp_ctl("frz_ctl", 0, 0, 0, 0);
      exp_tags("frz_tags", 10, 31, 31, 1, 0, 0, 0);
      tick();
    end
    branch_taken = 1'b0;
    mem_ready    = 1'b1;
    exp_ctl("frz_release_ctl", 1, 1, 0, 0);
    exp_tags("frz_release_tags", 10, 31, 31, 1, 0, 0, 0);
    exp_misc("frz_count", 0, 16'd4);
    tick();
    nop_in();
    exp_tags("frz_adv_tags", 11, 10, 31, 1, 1, 0, 0);
    tick();

    // Back-to-back ALU writes x2, x3, x4.
    for (int r = 2; r <= 4; r++) begin
      set_id(5'(r), 1, 0, 0);
      tick();
    end
    nop_in();
    exp_ctl("b2b_ctl", 1, 1, 0, 0);
    exp_tags("b2b_tags", 4, 3, 2, 1, 1, 1, 0);
    exp_misc("b2b_count", 0, 16'd4);
    tick();

    // Memory never ready: timeout after 16 stalled cycles, sticky.
    set_id(31, 0, 0, 1);
    tick();
    nop_in();
    tick();
    mem_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_ctl("tmo_frz_ctl", 0, 0, 0, 0);
      exp_misc("tmo_wait", 0, 16'(4 + k));
      tick();
    end
    mem_ready = 1'b1;
    exp_ctl("tmo_release_ctl", 1, 1, 0, 0);
    exp_misc("tmo_set", 1, 16'd20);
    tick();
    exp_misc("tmo_sticky", 1, 16'd20);
    exp_tags("tmo_drain_tags", 31, 31, 31, 0, 0, 0, 0);
    tick();

    // Reset in the middle of a memory wait clears everything.
    set_id(12, 1, 1, 1);
    tick();
    set_id(13, 1, 0, 0);
    tick();
    nop_in();
    mem_ready = 1'b0;
    exp_ctl("mid_frz_ctl", 0, 0, 0, 0);
    exp_tags("mid_frz_tags", 13, 12, 31, 1, 1, 0, 0);
    tick();
    reset = 1'b1;
    exp_ctl("mid_rst_ctl", 1, 1, 0, 0);
    tick();
    reset = 1'b0;
    exp_ctl("mid_rst_run_ctl", 1, 1, 0, 0);
    exp_tags("mid_rst_tags", 31, 31, 31, 0, 0, 0, 0);
    exp_misc("mid_rst_misc", 0, 16'd0);
    tick();
    mem_ready = 1'b1;
    tick();
    tick();

    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
